// File: rtl/vape_exec_flag.sv
// rtl/vape_exec_flag.sv - final attested EXEC flag for the executable region, with sticky causes and a violation count
module vape_exec_flag #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_en,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_en,
    input  logic              irq_dma_exec,
    input  logic [ADDR_W-1:0] ER_min,
    input  logic [ADDR_W-1:0] ER_max,
    input  logic [ADDR_W-1:0] OR_min,
    input  logic [ADDR_W-1:0] OR_max,
    output logic              exec,
    output logic [5:0]        viol_cause,
    output logic [CNT_W-1:0]  viol_cnt
);

    typedef enum logic [1:0] {
        ST_ABORT   = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc_prev;
    logic              prev_valid;

    logic pc_in_er;
    logic pc_prev_in_er;
    logic data_in_er;
    logic data_in_or;
    logic dma_in_er;
    logic dma_in_or;
    logic data_write;
    logic at_entry;
    logic legal_exit;
    logic [5:0] cause;
    logic viol;
    logic run_entry;

    assign pc_in_er      = (pc >= ER_min) && (pc <= ER_max);
    assign pc_prev_in_er = (pc_prev >= ER_min) && (pc_prev <= ER_max);
    assign data_in_er    = (data_addr >= ER_min) && (data_addr <= ER_max);
    assign data_in_or    = (data_addr >= OR_min) && (data_addr <= OR_max);
    assign dma_in_er     = (dma_addr >= ER_min) && (dma_addr <= ER_max);
    assign dma_in_or     = (dma_addr >= OR_min) && (dma_addr <= OR_max);
    assign data_write    = data_en && data_wr;
    assign at_entry      = (pc == ER_min);
    assign legal_exit    = !pc_in_er && (pc_prev == ER_max);

    // OR writes are only legitimate when issued by code inside the ER
    assign cause[0] = data_write && data_in_er;
    assign cause[1] = data_write && data_in_or && !pc_in_er;
    assign cause[2] = dma_en && (dma_in_er || dma_in_or);
    assign cause[3] = (state == ST_RUN) && !irq_dma_exec;
    assign cause[4] = prev_valid && pc_in_er && !pc_prev_in_er && !at_entry;
    assign cause[5] = prev_valid && (state == ST_RUN) && !pc_in_er && (pc_prev != ER_max);
    assign viol     = |cause;

    always_comb begin
        next_state = state;
        case (state)
            ST_ABORT: begin
                if (at_entry && !viol) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (viol)            next_state = ST_ABORT;
                else if (legal_exit) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (viol)          next_state = ST_ABORT;
                else if (at_entry) next_state = ST_RUN;
            end
            default: next_state = ST_ABORT;
        endcase
    end

    assign run_entry = ((state == ST_ABORT) || (state == ST_DONE)) && (next_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ABORT;
            exec       <= 1'b0;
            viol_cause <= '0;
            viol_cnt   <= '0;
            pc_prev    <= '0;
            prev_valid <= 1'b0;
        end else begin
            state      <= next_state;
            exec       <= (next_state == ST_DONE);
            pc_prev    <= pc;
            prev_valid <= 1'b1;
            if (viol)
                viol_cause <= viol_cause | cause;
            else if (run_entry)
                viol_cause <= '0;
            if (viol && (viol_cnt != '1))
                viol_cnt <= viol_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vape_exec_flag.sv
// tb/tb_vape_exec_flag.sv - directed bench for vape_exec_flag against a behavioural attestation model
module tb_vape_exec_flag;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        data_en;
    logic        data_wr;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic        irq_dma_exec;
    logic [15:0] er_lo;
    logic [15:0] er_hi;
    logic [15:0] or_lo;
    logic [15:0] or_hi;
    logic        exec;
    logic [5:0]  viol_cause;
    logic [7:0]  viol_cnt;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 0;

    vape_exec_flag #(.ADDR_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .data_addr    (data_addr),
        .data_en      (data_en),
        .data_wr      (data_wr),
        .dma_addr     (dma_addr),
        .dma_en       (dma_en),
        .irq_dma_exec (irq_dma_exec),
        .ER_min       (er_lo),
        .ER_max       (er_hi),
        .OR_min       (or_lo),
        .OR_max       (or_hi),
        .exec         (exec),
        .viol_cause   (viol_cause),
        .viol_cnt     (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "running" means an attested pass is in progress, "done" means it finished cleanly
    bit          m_run;
    bit          m_done;
    logic [5:0]  m_cause;
    int          m_cnt;
    logic [15:0] m_pc_prev;
    bit          m_pv;
    logic [5:0]  mc;

    function automatic bit inside_rng(input logic [15:0] x, input logic [15:0] lo, input logic [15:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_done = 0; m_cause = 6'h00; m_cnt = 0; m_pc_prev = 16'h0; m_pv = 0;
        end else begin
            mc    = 6'h00;
            mc[0] = data_en && data_wr && inside_rng(data_addr, er_lo, er_hi);
            mc[1] = data_en && data_wr && inside_rng(data_addr, or_lo, or_hi) && !inside_rng(pc, er_lo, er_hi);
            mc[2] = dma_en && (inside_rng(dma_addr, er_lo, er_hi) || inside_rng(dma_addr, or_lo, or_hi));
            mc[3] = m_run && !irq_dma_exec;
            mc[4] = m_pv && inside_rng(pc, er_lo, er_hi) && !inside_rng(m_pc_prev, er_lo, er_hi) && (pc != er_lo);
            mc[5] = m_pv && m_run && !inside_rng(pc, er_lo, er_hi) && (m_pc_prev != er_hi);
            if (mc != 6'h00) begin
                m_cause = m_cause | mc;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_run = 0; m_done = 0;
            end else if (m_run) begin
                if (!inside_rng(pc, er_lo, er_hi) && (m_pc_prev == er_hi)) begin
                    m_run = 0; m_done = 1;
                end
            end else if (pc == er_lo) begin
                m_run = 1; m_done = 0; m_cause = 6'h00;
            end
            m_pc_prev = pc;
            m_pv = 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_exec",  int'(exec),       int'(m_done));
            check("model_cause", int'(viol_cause), int'(m_cause));
            check("model_cnt",   int'(viol_cnt),   m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic [15:0] p);
        pc = p;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; data_en = 0; data_wr = 0; dma_en = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic walk_er(input int from, input int to);
        for (int a = from; a <= to; a += 2) step(16'(a));
    endtask

    task automatic legal_run();
        step(16'hE000);
        walk_er(16'hE002, 16'hE0FE);
        step(16'h4002);
    endtask

    initial begin
        reset = 1'b1; pc = 16'h0; data_addr = 16'h0; data_en = 0; data_wr = 0;
        dma_addr = 16'h0; dma_en = 0; irq_dma_exec = 0;
        er_lo = 16'hE000; er_hi = 16'hE0FE; or_lo = 16'h0200; or_hi = 16'h021F;
        tick();
        cmp_en = 1;
        tick();
        check("reset_exec", int'(exec), 0);
        check("reset_cause", int'(viol_cause), 0);
        check("reset_cnt", int'(viol_cnt), 0);
        reset = 1'b0;

        // 1 legal run
        step(16'h4000);
        step(16'hE000);
        irq_dma_exec = 1;
        walk_er(16'hE002, 16'hE0FE);
        check("t1_exec_before_exit", int'(exec), 0);
        step(16'h4002);
        check("t1_exec", int'(exec), 1);
        check("t1_cause", int'(viol_cause), 0);
        check("t1_cnt", int'(viol_cnt), 0);

        // 2 DMA into OR during run
        do_reset();
        step(16'h4000);
        step(16'hE000);
        walk_er(16'hE002, 16'hE00E);
        dma_en = 1; dma_addr = 16'h0210;
        step(16'hE010);
        dma_en = 0;
        walk_er(16'hE012, 16'hE0FE);
        step(16'h4002);
        step(16'h4004);
        check("t2_exec", int'(exec), 0);
        check("t2_cause", int'(viol_cause), 6'h04);
        check("t2_cnt", int'(viol_cnt), 1);

        // 3 bad entry
        do_reset();
        step(16'h4000);
        step(16'hE020);
        check("t3_cause", int'(viol_cause), 6'h10);
        check("t3_exec", int'(exec), 0);
        step(16'hE0FE);
        step(16'h4002);
        check("t3_no_done", int'(exec), 0);
        check("t3_cnt", int'(viol_cnt), 1);

        // 4 bad exit
        do_reset();
        step(16'h4000);
        step(16'hE000);
        walk_er(16'hE002, 16'hE010);
        step(16'h4000);
        check("t4_cause", int'(viol_cause), 6'h20);
        check("t4_exec", int'(exec), 0);

        // 5 post-run tamper, then re-run clears causes; OR write from ER code and DMA just outside OR are legal
        step(16'hE000);
        check("t5_clear_on_entry", int'(viol_cause), 0);
        walk_er(16'hE002, 16'hE0FE);
        step(16'h4002);
        check("t5_exec_up", int'(exec), 1);
        data_en = 1; data_wr = 1; data_addr = 16'h0205;
        step(16'h5000);
        data_en = 0; data_wr = 0;
        check("t5_tamper_exec", int'(exec), 0);
        check("t5_tamper_cause", int'(viol_cause), 6'h02);
        check("t5_tamper_cnt", int'(viol_cnt), 2);
        step(16'hE000);
        check("t5_rerun_clear", int'(viol_cause), 0);
        data_en = 1; data_wr = 1; data_addr = 16'h021F; dma_en = 1; dma_addr = 16'h0220;
        step(16'hE002);
        data_en = 0; data_wr = 0; dma_en = 0;
        walk_er(16'hE004, 16'hE0FE);
        step(16'h4002);
        check("t5_rerun_exec", int'(exec), 1);
        check("t5_rerun_cnt", int'(viol_cnt), 2);
        step(16'hE000);
        check("t5_reexec_drops", int'(exec), 0);

        // 7 atomicity loss
        do_reset();
        step(16'h4000);
        step(16'hE000);
        irq_dma_exec = 0;
        step(16'hE002);
        irq_dma_exec = 1;
        check("t7_cause", int'(viol_cause), 6'h08);

        // 8 single-instruction ER
        er_hi = 16'hE000;
        do_reset();
        step(16'h4000);
        step(16'hE000);
        step(16'h4002);
        check("t8_exec", int'(exec), 1);
        er_hi = 16'hE0FE;

        // 6 counter saturation, then reset mid-run
        do_reset();
        pc = 16'h4000;
        data_en = 1; data_wr = 1; data_addr = 16'hE000;
        for (int i = 0; i < 300; i++) tick();
        data_en = 0; data_wr = 0;
        check("t6_sat", int'(viol_cnt), 255);
        step(16'hE000);
        step(16'hE002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_exec", int'(exec), 0);
        check("t6_rst_cnt", int'(viol_cnt), 0);
        check("t6_rst_cause", int'(viol_cause), 0);
        step(16'hE004);
        step(16'hE006);
        step(16'h4000);
        check("t6_no_prev_viol", int'(viol_cnt), 0);
        check("t6_fresh_entry", int'(exec), 0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
